// File: rtl/term_pkg.sv
// term_pkg: shared constants, decoder states and line buffer type for term_line_ctrl.
package term_pkg;
    localparam int N_POS = 4;
    localparam logic [7:0] ASCII_ESC    = 8'h1B;
    localparam logic [7:0] ASCII_LBRACK = 8'h5B;
    localparam logic [7:0] ASCII_BS     = 8'h08;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_SPACE  = 8'h20;
    localparam logic [7:0] ASCII_TILDE  = 8'h7E;
    localparam logic [7:0] ASCII_C      = 8'h43;
    localparam logic [7:0] ASCII_D      = 8'h44;
    localparam logic [7:0] ASCII_3      = 8'h33;
    localparam logic [7:0] ASCII_US     = 8'h5F;

    typedef enum logic [2:0] {S_IDLE, S_ESC, S_CSI, S_CSI3, S_DEL, S_BS_MOVE} state_t;
    typedef logic [N_POS-1:0][7:0] line_t;

    function automatic logic [1:0] oh2idx(input logic [N_POS-1:0] oh);
        logic [1:0] r;
        r = '0;
        for (int k = 0; k < N_POS; k++) if (oh[k]) r = 2'(k);
        return r;
    endfunction
endpackage

// File: rtl/disp_scan.sv
// disp_scan: digit scan counter and one-hot digit rotation for the 4-digit display.
// With TERM_CURSOR_BLINK_EN defined, also a blink flag toggling every 64 full scan rounds.
module disp_scan #(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] dig_sel,
    output logic       blink
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    logic [CW-1:0] cnt;
    logic wrap;
    assign wrap = cnt == CW'(SCAN_DIV - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            dig_sel <= 4'b0001;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap) dig_sel <= {dig_sel[2:0], dig_sel[3]};
        end
    end

`ifdef TERM_CURSOR_BLINK_EN
    logic [5:0] rounds;
    // A round completes when the last digit's slot wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rounds <= '0;
            blink <= 1'b0;
        end else if (wrap && dig_sel[3]) begin
            rounds <= rounds + 1'b1;
            if (&rounds) blink <= ~blink;
        end
    end
`else
    assign blink = 1'b0;
`endif
endmodule

// File: rtl/term_line_ctrl.sv
// term_line_ctrl: VT100-style byte decoder and 4-position line editor with multiplexed display.
// Cursor blink on the display is enabled by defining TERM_CURSOR_BLINK_EN.
module term_line_ctrl
    import term_pkg::*;
#(
    parameter int SCAN_DIV    = 1000,
    parameter int ESC_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  inp,
    input  logic        priem,
    output logic        ready,
    output logic [3:0]  cursor,
    output logic [3:0]  dig_sel,
    output logic [7:0]  dig_char,
    output logic        line_done,
    output logic [31:0] line_data,
    output logic        err
);
    localparam int TW = $clog2(ESC_TIMEOUT + 1);

    state_t        st;
    line_t         buffer;
    logic [1:0]    del_i;
    logic [TW-1:0] tcnt;
    logic          blink, acc, in_esc, tout, esc_ok;
    logic [1:0]    idx;

    assign acc    = priem && ready;
    assign in_esc = st inside {S_ESC, S_CSI, S_CSI3};
    assign tout   = in_esc && !acc && tcnt == TW'(ESC_TIMEOUT - 1);
    assign idx    = oh2idx(cursor);
    assign esc_ok = (st == S_ESC && inp == ASCII_LBRACK) ||
                    (st == S_CSI && inp inside {ASCII_C, ASCII_D, ASCII_3}) ||
                    (st == S_CSI3 && inp == ASCII_TILDE);

    disp_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (.clk(clk), .rst_n(rst_n), .dig_sel(dig_sel), .blink(blink));

    always_comb dig_char = (blink && dig_sel == cursor) ? ASCII_US : buffer[oh2idx(dig_sel)];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= S_IDLE;
            buffer    <= {N_POS{ASCII_SPACE}};
            cursor    <= 4'b0001;
            ready     <= 1'b1;
            line_done <= 1'b0;
            line_data <= {N_POS{ASCII_SPACE}};
            err       <= 1'b0;
            del_i     <= '0;
            tcnt      <= '0;
        end else begin
            line_done <= 1'b0;
            err       <= priem && !ready;
            tcnt      <= (acc || !in_esc) ? '0 : tcnt + 1'b1;
            case (st)
                S_IDLE: if (acc) begin
                    if (inp inside {[ASCII_SPACE:ASCII_TILDE]}) begin
                        buffer[idx] <= inp;
                        if (!cursor[3]) cursor <= cursor << 1;
                    end else if (inp == ASCII_BS && !cursor[0]) begin
                        st    <= S_BS_MOVE;
                        ready <= 1'b0;
                    end else if (inp == ASCII_CR) begin
                        line_data <= buffer;
                        line_done <= 1'b1;
                        buffer    <= {N_POS{ASCII_SPACE}};
                        cursor    <= 4'b0001;
                    end else if (inp == ASCII_ESC) begin
                        st <= S_ESC;
                    end
                end
                S_ESC, S_CSI, S_CSI3: if (acc) begin
                    err <= !esc_ok;
                    st  <= inp == ASCII_ESC ? S_ESC : !esc_ok ? S_IDLE : st == S_ESC ? S_CSI :
                           st == S_CSI3 ? S_DEL : inp == ASCII_3 ? S_CSI3 : S_IDLE;
                    if (st == S_CSI && inp == ASCII_C && !cursor[3]) cursor <= cursor << 1;
                    if (st == S_CSI && inp == ASCII_D && !cursor[0]) cursor <= cursor >> 1;
                    if (esc_ok && st == S_CSI3) begin
                        del_i <= idx;
                        ready <= 1'b0;
                    end
                end else if (tout) begin
                    err <= 1'b1;
                    st  <= S_IDLE;
                end
                S_BS_MOVE: begin
                    cursor <= cursor >> 1;
                    del_i  <= idx - 2'd1;
                    st     <= S_DEL;
                end
                S_DEL: if (del_i == 2'd3) begin
                    buffer[3] <= ASCII_SPACE;
                    ready     <= 1'b1;
                    st        <= S_IDLE;
                end else begin
                    buffer[del_i] <= buffer[del_i + 2'd1];
                    del_i         <= del_i + 2'd1;
                end
                default: st <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/term_line_ctrl.md
# term_line_ctrl

Byte-stream line editor controller for the 4-position character display. Accepts a strobed ASCII/VT100 byte stream, decodes control bytes and CSI escape sequences, and sequences the edits on a 4-character line buffer with a one-hot cursor. It also time-multiplexes that buffer onto the shared 4-digit display, and emits the finished line on Enter.

## Interface
- SCAN_DIV, 1000: clk cycles each digit is driven before the scanner advances (≥2).
- ESC_TIMEOUT, 4096: idle cycles allowed inside an escape sequence before it is aborted.
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- inp  in  8  received byte
- priem  in  1  byte strobe; byte accepted on an edge where priem && ready
- ready  out  1  controller can accept a byte this cycle
- cursor  out  4  one-hot cursor position, bit0 = leftmost
- dig_sel  out  4  one-hot digit enable for the display
- dig_char  out  8  character code for the enabled digit
- line_done  out  1  one-cycle pulse: line committed by Enter
- line_data  out  32  committed line, pos0 in [7:0]
- err  out  1  one-cycle pulse: malformed sequence, timeout, or byte dropped

## Operation
- Reset: state IDLE, buffer all 0x20, cursor 0001, ready 1, line_done 0, line_data all 0x20, err 0, dig_sel 0001, scan/timeout counters 0.
- Decoder states: IDLE, ESC, CSI, CSI3, DEL, BS_MOVE. ready=1 in IDLE/ESC/CSI/CSI3, 0 in DEL/BS_MOVE.
- IDLE, byte 0x20–0x7E: write it at cursor, advance cursor one position; at pos3 the byte overwrites pos3 and the cursor stays.
- IDLE 0x08 (Backspace): at pos0, no-op. Otherwise BS_MOVE (cursor moves left one position), then DEL at the new position.
- IDLE 0x0D (Enter): line_data <= buffer and line_done=1. On the same edge the buffer is set to all 0x20 and the cursor to 0001.
- IDLE 0x1B: go to ESC. Any other byte is ignored silently.
- ESC: '[' (0x5B) goes to CSI. Any other byte pulses err and returns to IDLE; the byte is discarded.
- CSI:
  - 'C' (0x43): cursor right, saturating at 1000; go to IDLE.
  - 'D' (0x44): cursor left, saturating at 0001; go to IDLE.
  - '3' (0x33): go to CSI3.
  - Any other byte: err, go to IDLE.
- CSI3: '~' (0x7E) goes to DEL at the current cursor position. Any other byte: err, go to IDLE.
- 0x1B received in ESC, CSI or CSI3: pulse err and restart at ESC.
- Timeout: in ESC, CSI or CSI3, ESC_TIMEOUT consecutive cycles without an accepted byte pulse err and return to IDLE. The counter clears on every accept.
- DEL at index i: one shift per cycle, buf[k] <= buf[k+1] for k = i..2, then a final cycle writing 0x20 to pos3. The cursor does not move.
- priem while ready=0: the byte is dropped and err pulses.
- Scanner: a counter runs 0..SCAN_DIV-1. On wrap, dig_sel rotates left (1000→0001). dig_char = buffer[index of dig_sel].

## Timing
- All outputs registered except dig_char (combinational from buffer and dig_sel).
- Buffer, cursor and line_data update on the edge after the accepting edge. line_done and err are high for exactly the cycle that follows.
- DEL keeps ready low for 4−i cycles (i = position, 0..3).
- Backspace from position p (p≥1) keeps ready low for 1 + (4−(p−1)) cycles.
- Edits are visible on dig_char in the cycle they land in the buffer.
- Mid-operation rst_n: everything returns to reset values immediately. A partial shift is discarded.

## Configuration
- TERM_CURSOR_BLINK_EN defined:
  - A blink flag toggles every 64 complete scan rounds (64·4·SCAN_DIV cycles).
  - While the flag is 1 and dig_sel equals cursor, dig_char = 0x5F ('_').
  - Reset flag = 0.
- Undefined: no blink logic; the cursor is indicated only on the cursor output.

## Structure
- Package term_pkg holds:
  - N_POS=4
  - ASCII constants (ESC, LBRACK, BS, CR, SPACE, TILDE, 'C', 'D', '3', '_')
  - Decoder state enum
  - Line buffer typedef (N_POS×8)
- Sub-module disp_scan: SCAN_DIV counter, dig_sel rotation and, under the macro, the blink flag. term_line_ctrl instantiates it once.

## Test plan
- Reset, send 'A','B' → buffer "AB  ", cursor 0100; send 'X','Y','Z' → "ABXZ", cursor 1000.
- "ABCD", then ESC [ D, ESC [ D (cursor 0010), then ESC [ 3 ~ → buffer "ACD ", ready low 3 cycles, cursor 0010.
- "AB" then 0x08 → buffer "A   ", cursor 0010. Then 0x08 again → "    ", cursor 0001. Then 0x08 at pos0 → no change, no err.
- "HI", 0x0D → line_done one cycle, line_data "HI  ", buffer all 0x20, cursor 0001.
- ESC then 'X' → err pulse, IDLE. ESC with no following byte → err after exactly ESC_TIMEOUT cycles. ESC [ 3 then 0x1B → err, state ESC.
- SCAN_DIV=4, buffer "WXYZ" → dig_sel rotates every 4 cycles, dig_char 'W','X','Y','Z'. Byte strobed during DEL → dropped, err pulse, buffer unaffected.
